mem_arbiter: RTL and testbench

//  Shares the single-port main memory between instruction fetch (I port) and

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter between fetch and load/store ports onto single-port main memory.
// Sub-word stores become read-modify-write sequences on whole words.
module mem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter logic [31:0] MEM_BYTES = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write
);

    typedef enum logic [2:0] {
        IDLE, ACCESS, RMW_RD, RMW_WR, DONE
    } state_e;

    state_e      state_q, state_d;
    logic        port_q, port_d;
    logic        last_d_q, last_d_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        i_err_q, i_err_d;
    logic        d_err_q, d_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        gnt_d;
    logic [31:0] req_addr;
    logic        misal;
    logic        oor;
    logic        sub;
    logic [31:0] merged;

    // D wins when alone, or on a tie when I was granted last
    assign gnt_d = d_req && (!i_req || !last_d_q);
    assign req_addr = gnt_d ? d_addr : i_addr;
    assign oor = (req_addr < BASE_ADDR) ||
                 ((req_addr - BASE_ADDR) >= MEM_BYTES);
    assign sub = gnt_d && d_we && (d_size[1] == 1'b0);

    always_comb begin
        misal = (req_addr[1:0] != 2'b00);
        if (gnt_d) begin
            unique case (d_size)
                2'd0:    misal = 1'b0;
                2'd1:    misal = req_addr[0];
                default: misal = (req_addr[1:0] != 2'b00);
            endcase
        end
    end

    always_comb begin
        merged = merge_q;
        if (size_q == 2'd0)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    assign mem_address = {addr_q[31:2], 2'b00};
    assign mem_read_write = (state_q == RMW_WR) ||
                            ((state_q == ACCESS) && we_q);

    always_comb begin
        mem_data_in = 32'h0;
        if (state_q == RMW_WR)
            mem_data_in = merged;
        else if ((state_q == ACCESS) && we_q)
            mem_data_in = wdata_q;
    end

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        size_d    = size_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    port_d   = gnt_d;
                    last_d_d = gnt_d;
                    addr_d   = req_addr;
                    size_d   = gnt_d ? d_size : 2'd2;
                    we_d     = gnt_d && d_we;
                    wdata_d  = d_wdata;
                    if (misal || oor) begin
                        state_d = DONE;
                        d_ack_d = gnt_d;
                        d_err_d = gnt_d;
                        i_ack_d = !gnt_d;
                        i_err_d = !gnt_d;
                    end else begin
                        state_d = sub ? RMW_RD : ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = DONE;
                d_ack_d = port_q;
                i_ack_d = !port_q;
                if (!we_q) begin
                    if (port_q) d_rdata_d = mem_data_out;
                    else        i_rdata_d = mem_data_out;
                end
            end
            RMW_RD: begin
                merge_d = mem_data_out;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                state_d = DONE;
                d_ack_d = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            last_d_q  <= 1'b0;
            addr_q    <= BASE_ADDR;
            size_q    <= 2'd2;
            we_q      <= 1'b0;
            wdata_q   <= 32'h0;
            merge_q   <= 32'h0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            last_d_q  <= last_d_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            merge_q   <= merge_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_err   = i_err_q;
    assign d_err   = d_err_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory model, directed and random steps.
module tb_mem_arbiter;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] MEMB = 32'h0010_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = BASE;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'd2;
    logic [31:0] d_addr = BASE;
    logic [31:0] d_wdata = 32'h0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;

    mem_arbiter #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
        .clock(clock), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_read_write(mem_read_write)
    );

    always #5 clock = ~clock;

    // mainmem window of 1 KiB at BASE; reference kept as bytes
    logic [31:0] mm [0:255];
    logic [7:0]  rb [0:1023];
    int nchk = 0;
    int nerr = 0;
    int wr_cnt = 0;
    int bad_wr = 0;
    bit lg_d = 1'b0;

    logic in_win;
    assign in_win = (mem_address >= BASE) && (mem_address < BASE + 1024);
    assign mem_data_out = in_win ? mm[mem_address[9:2]] : 32'hDEAD_BEEF;

    always @(posedge clock) begin
        if (mem_read_write) begin
            wr_cnt <= wr_cnt + 1;
            if (in_win) mm[mem_address[9:2]] <= mem_data_in;
            else bad_wr <= bad_wr + 1;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rword(logic [31:0] a);
        int b;
        b = int'((a - BASE) & 32'h3FC);
        return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
    endfunction

    function automatic bit exp_err(bit isd, logic [1:0] sz,
                                   logic [31:0] a);
        int al;
        al = !isd ? 4 : (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        return (a % al != 0) || (a < BASE) || (a - BASE >= MEMB);
    endfunction

    task automatic xact(bit isd, bit we, logic [1:0] sz,
                        logic [31:0] a, logic [31:0] wd);
        bit e;
        int lat, cyc, w0, nb, off;
        bit got, other;
        e = exp_err(isd, sz, a);
        lat = e ? 1 : (isd && we && sz < 2) ? 3 : 2;
        @(negedge clock);
        w0 = wr_cnt;
        if (isd) begin
            d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        end else begin
            i_req = 1; i_addr = a;
        end
        cyc = 0; got = 0; other = 0;
        while (!got && cyc < 8) begin
            @(negedge clock);
            cyc++;
            got = isd ? d_ack : i_ack;
            if (isd ? i_ack : d_ack) other = 1;
        end
        d_req = 0; i_req = 0;
        chk("latency", cyc, lat);
        chk("other_ack", {31'h0, other}, 0);
        chk("err", {31'h0, isd ? d_err : i_err}, {31'h0, e});
        if (!e && !(isd && we))
            chk("rdata", isd ? d_rdata : i_rdata, rword(a));
        chk("writes", wr_cnt - w0, (!e && isd && we) ? 1 : 0);
        if (!e && isd && we) begin
            nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
            off = int'(a - BASE);
            for (int k = 0; k < nb; k++) rb[off+k] = wd[8*k +: 8];
            chk("memword", mm[off/4], rword(a));
        end
        lg_d = isd;
    endtask

    task automatic tie(logic [31:0] ia, logic [31:0] da);
        bit exp_first_d, first_set, first_d;
        bit gi, gd;
        int cyc;
        exp_first_d = !lg_d;
        @(negedge clock);
        i_req = 1; i_addr = ia;
        d_req = 1; d_we = 0; d_size = 2'd2; d_addr = da;
        cyc = 0; gi = 0; gd = 0; first_set = 0; first_d = 0;
        while (!(gi && gd) && cyc < 16) begin
            @(negedge clock);
            cyc++;
            if (d_ack && !gd) begin
                gd = 1; d_req = 0;
                chk("tie_drdata", d_rdata, rword(da));
                if (!first_set) begin first_set = 1; first_d = 1; end
            end
            if (i_ack && !gi) begin
                gi = 1; i_req = 0;
                chk("tie_irdata", i_rdata, rword(ia));
                if (!first_set) begin first_set = 1; first_d = 0; end
            end
        end
        i_req = 0; d_req = 0;
        chk("tie_both", {30'h0, gi, gd}, 32'h3);
        chk("tie_first", {31'h0, first_d}, {31'h0, exp_first_d});
        chk("tie_cycles", cyc, 5);
        lg_d = !exp_first_d;
    endtask

    initial begin
        logic [31:0] a, w;
        int w0;
        for (int i = 0; i < 1024; i++) rb[i] = 8'($urandom);
        {rb[3], rb[2], rb[1], rb[0]} = 32'h0000_0297;
        for (int i = 0; i < 256; i++) mm[i] = rword(BASE + 32'(4*i));

        repeat (3) @(negedge clock);
        chk("rst_iack", {31'h0, i_ack}, 0);
        chk("rst_dack", {31'h0, d_ack}, 0);
        chk("rst_errs", {30'h0, i_err, d_err}, 0);
        chk("rst_irdata", i_rdata, 0);
        chk("rst_drdata", d_rdata, 0);
        chk("rst_rw", {31'h0, mem_read_write}, 0);
        chk("rst_addr", mem_address, BASE);
        chk("rst_din", mem_data_in, 0);
        reset_n = 1;
        lg_d = 0;

        xact(0, 0, 2, BASE, 0);
        chk("fetch0", i_rdata, 32'h0000_0297);
        tie(BASE + 4, BASE + 32'h10);
        tie(BASE + 8, BASE + 32'h14);
        xact(1, 0, 2, BASE + 32'h18, 0);
        tie(BASE + 12, BASE + 32'h1C);

        xact(1, 1, 2, BASE + 8, 32'hAABB_CCDD);
        xact(1, 1, 0, BASE + 9, 32'h0000_0011);
        chk("byte_rmw", mm[2], 32'hAABB_11DD);
        xact(1, 1, 1, BASE + 32'h0A, 32'h0000_BEEF);
        chk("half_rmw", mm[2], 32'hBEEF_11DD);
        xact(1, 1, 1, BASE + 32'h0B, 32'h0000_1234);
        chk("half_mis", mm[2], 32'hBEEF_11DD);
        w = i_rdata;
        xact(1, 0, 2, BASE + MEMB, 0);
        xact(0, 0, 2, BASE - 4, 0);
        xact(1, 0, 0, BASE - 1, 0);
        chk("irdata_hold", i_rdata, w);

        // reset during read phase of a byte store
        @(negedge clock);
        w0 = wr_cnt;
        d_req = 1; d_we = 1; d_size = 0;
        d_addr = BASE + 32'h21; d_wdata = 32'h55;
        @(negedge clock);
        reset_n = 0;
        #1;
        chk("rst1_rw", {31'h0, mem_read_write}, 0);
        d_req = 0;
        repeat (2) begin
            @(negedge clock);
            chk("rst1_ack", {30'h0, i_ack, d_ack}, 0);
        end
        reset_n = 1;
        lg_d = 0;
        chk("rst1_wr", wr_cnt - w0, 0);
        chk("rst1_mem", mm[8], rword(BASE + 32'h20));
        chk("rst1_addr", mem_address, BASE);

        // reset while the write cycle is being presented
        @(negedge clock);
        w0 = wr_cnt;
        d_req = 1; d_we = 1; d_size = 0;
        d_addr = BASE + 32'h22; d_wdata = 32'h66;
        repeat (2) @(negedge clock);
        chk("rmw_wr_rw", {31'h0, mem_read_write}, 1);
        reset_n = 0;
        #1;
        chk("rst2_rw", {31'h0, mem_read_write}, 0);
        d_req = 0;
        @(negedge clock);
        reset_n = 1;
        lg_d = 0;
        chk("rst2_wr", wr_cnt - w0, 0);
        chk("rst2_mem", mm[8], rword(BASE + 32'h20));
        tie(BASE + 32'h30, BASE + 32'h34);

        for (int n = 0; n < 80; n++) begin
            bit isd, we;
            logic [1:0] sz;
            case ($urandom_range(0, 9))
                0:       a = BASE + MEMB + 32'($urandom_range(0, 7));
                1:       a = BASE - 32'($urandom_range(1, 8));
                default: a = BASE + 32'($urandom_range(0, 1023));
            endcase
            isd = 1'($urandom);
            we = isd && 1'($urandom);
            sz = 2'($urandom);
            if ($urandom_range(0, 7) == 0)
                tie(BASE + 32'(4 * $urandom_range(0, 255)),
                    BASE + 32'(4 * $urandom_range(0, 255)));
            else
                xact(isd, we, sz, a, $urandom);
        end

        for (int i = 0; i < 256; i++)
            if (mm[i] !== rword(BASE + 32'(4*i)))
                chk("final_mem", mm[i], rword(BASE + 32'(4*i)));
        chk("oob_write", bad_wr, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
